// File: rtl/stream_downsizer.sv
// stream_downsizer: splits RATIO-lane words into WIDTH-bit beats, lane 0 first, with last-beat framing.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_data, i_nbeats, i_vld / o_rdy : wide input word, valid lanes minus 1, handshake
//   o_data, o_last, o_vld / i_rdy   : narrow output lane, final-lane marker, handshake
module stream_downsizer #(
   parameter int WIDTH = 8,
   parameter int RATIO = 4
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic [WIDTH*RATIO-1:0]     i_data,
   input  logic [$clog2(RATIO)-1:0]   i_nbeats,
   input  logic                       i_vld,
   output logic                       o_rdy,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_vld,
   output logic                       o_last,
   input  logic                       i_rdy
);
   localparam int CW = $clog2(RATIO);
   logic                   r_busy;
   logic [WIDTH*RATIO-1:0] r_shreg;
   logic [CW-1:0]          r_cnt;
   logic                   w_cnt_zero;
   logic                   w_accept;
   logic                   w_xfer;
   assign w_cnt_zero = r_cnt == '0;
   // i_rdy reaches o_rdy only on the final beat, so a new word can load as the old one leaves
   assign o_rdy      = !r_busy || (i_rdy && w_cnt_zero);
   assign o_vld      = r_busy;
   assign o_data     = r_shreg[WIDTH-1:0];
   assign o_last     = r_busy && w_cnt_zero;
   assign w_accept   = i_vld && o_rdy;
   assign w_xfer     = r_busy && i_rdy;
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_busy  <= 1'b0;
         r_shreg <= '0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_busy  <= 1'b1;
         r_shreg <= i_data;
         r_cnt   <= i_nbeats;
      end else if (w_xfer) begin
         if (!w_cnt_zero) begin
            r_shreg <= {{WIDTH{1'b0}}, r_shreg[WIDTH*RATIO-1:WIDTH]};
            r_cnt   <= r_cnt - CW'(1);
         end else begin
            r_busy  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_stream_downsizer.sv
// tb_stream_downsizer: directed and randomised checks of stream_downsizer with WIDTH=8, RATIO=4.
module tb_stream_downsizer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] i_data;
   logic [1:0]  i_nbeats;
   logic        i_vld;
   logic        o_rdy;
   logic [7:0]  o_data;
   logic        o_vld;
   logic        o_last;
   logic        i_rdy;
   int          n_asserts = 0;
   int          n_fail = 0;

   stream_downsizer #(.WIDTH(8), .RATIO(4)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_data(i_data), .i_nbeats(i_nbeats), .i_vld(i_vld),
      .o_rdy(o_rdy), .o_data(o_data), .o_vld(o_vld), .o_last(o_last), .i_rdy(i_rdy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // settle combinational outputs, then compare all four outputs
   task automatic expect_out(input string tag, input logic vld, input logic [7:0] data,
                             input logic last, input logic rdy);
      #1;
      chk({tag, ".vld"}, 32'(o_vld), 32'(vld));
      if (vld) chk({tag, ".data"}, 32'(o_data), 32'(data));
      chk({tag, ".last"}, 32'(o_last), 32'(last));
      chk({tag, ".rdy"}, 32'(o_rdy), 32'(rdy));
   endtask

   task automatic send(input logic [31:0] d, input logic [1:0] nb);
      i_vld = 1'b1; i_data = d; i_nbeats = nb;
   endtask

   logic [8:0]  q[$];
   logic [8:0]  e;
   logic        prev_vld, prev_xfer, acc;
   int          words, cycles;

   initial begin
      rst_n = 1'b0; i_vld = 1'b0; i_data = '0; i_nbeats = '0; i_rdy = 1'b1;
      #12;
      expect_out("reset", 1'b0, 8'h00, 1'b0, 1'b1);
      chk("reset.data", 32'(o_data), 32'h0);
      #3 rst_n = 1'b1;
      tick;
      // full word
      send(32'hDDCCBBAA, 2'd3);
      expect_out("full.idle", 1'b0, 8'h00, 1'b0, 1'b1);
      tick; i_vld = 1'b0;
      expect_out("full.b0", 1'b1, 8'hAA, 1'b0, 1'b0);
      tick; expect_out("full.b1", 1'b1, 8'hBB, 1'b0, 1'b0);
      tick; expect_out("full.b2", 1'b1, 8'hCC, 1'b0, 1'b0);
      tick; expect_out("full.b3", 1'b1, 8'hDD, 1'b1, 1'b1);
      tick; expect_out("full.done", 1'b0, 8'h00, 1'b0, 1'b1);
      // back-to-back words
      send(32'h44332211, 2'd3);
      tick; send(32'h88776655, 2'd3);
      expect_out("b2b.b0", 1'b1, 8'h11, 1'b0, 1'b0);
      tick; expect_out("b2b.b1", 1'b1, 8'h22, 1'b0, 1'b0);
      tick; expect_out("b2b.b2", 1'b1, 8'h33, 1'b0, 1'b0);
      tick; expect_out("b2b.b3", 1'b1, 8'h44, 1'b1, 1'b1);
      tick; i_vld = 1'b0;
      expect_out("b2b.b4", 1'b1, 8'h55, 1'b0, 1'b0);
      tick; expect_out("b2b.b5", 1'b1, 8'h66, 1'b0, 1'b0);
      tick; expect_out("b2b.b6", 1'b1, 8'h77, 1'b0, 1'b0);
      tick; expect_out("b2b.b7", 1'b1, 8'h88, 1'b1, 1'b1);
      tick; expect_out("b2b.done", 1'b0, 8'h00, 1'b0, 1'b1);
      // partial words
      send(32'hFFEEDDCC, 2'd1);
      tick; send(32'h000000A5, 2'd0);
      expect_out("part.b0", 1'b1, 8'hCC, 1'b0, 1'b0);
      tick; expect_out("part.b1", 1'b1, 8'hDD, 1'b1, 1'b1);
      tick; i_vld = 1'b0;
      expect_out("part.b2", 1'b1, 8'hA5, 1'b1, 1'b1);
      tick; expect_out("part.done", 1'b0, 8'h00, 1'b0, 1'b1);
      // downstream stall on BB
      send(32'hDDCCBBAA, 2'd3);
      tick; i_vld = 1'b0;
      expect_out("stall.b0", 1'b1, 8'hAA, 1'b0, 1'b0);
      tick; i_rdy = 1'b0;
      expect_out("stall.h0", 1'b1, 8'hBB, 1'b0, 1'b0);
      tick; expect_out("stall.h1", 1'b1, 8'hBB, 1'b0, 1'b0);
      tick; expect_out("stall.h2", 1'b1, 8'hBB, 1'b0, 1'b0);
      tick; i_rdy = 1'b1;
      expect_out("stall.b1", 1'b1, 8'hBB, 1'b0, 1'b0);
      tick; expect_out("stall.b2", 1'b1, 8'hCC, 1'b0, 1'b0);
      tick; expect_out("stall.b3", 1'b1, 8'hDD, 1'b1, 1'b1);
      tick; expect_out("stall.done", 1'b0, 8'h00, 1'b0, 1'b1);
      // asynchronous reset mid-word, after BB has transferred
      send(32'hDDCCBBAA, 2'd3);
      tick; i_vld = 1'b0;
      tick; expect_out("rst.b1", 1'b1, 8'hBB, 1'b0, 1'b0);
      tick; rst_n = 1'b0;
      expect_out("rst.mid", 1'b0, 8'h00, 1'b0, 1'b1);
      chk("rst.mid.data", 32'(o_data), 32'h0);
      tick; rst_n = 1'b1;
      send(32'h04030201, 2'd3);
      expect_out("rst.idle", 1'b0, 8'h00, 1'b0, 1'b1);
      tick; i_vld = 1'b0;
      expect_out("rst.b0", 1'b1, 8'h01, 1'b0, 1'b0);
      tick; expect_out("rst.b1n", 1'b1, 8'h02, 1'b0, 1'b0);
      tick; expect_out("rst.b2n", 1'b1, 8'h03, 1'b0, 1'b0);
      tick; expect_out("rst.b3n", 1'b1, 8'h04, 1'b1, 1'b1);
      tick; expect_out("rst.done", 1'b0, 8'h00, 1'b0, 1'b1);
      // random soak against a lane scoreboard
      words = 0; cycles = 0; acc = 1'b0; prev_vld = 1'b0; prev_xfer = 1'b0;
      while ((words < 4000 || q.size() != 0 || o_vld) && cycles < 60000) begin
         if (!(i_vld && !acc)) begin
            i_vld = (words < 4000) && ($urandom_range(0, 3) != 0);
            i_data = $urandom;
            i_nbeats = 2'($urandom_range(0, 3));
         end
         i_rdy = (words >= 4000) || ($urandom_range(0, 3) != 0);
         #1;
         if (prev_vld && !prev_xfer) chk("soak.vld_hold", 32'(o_vld), 32'h1);
         if (o_vld && i_rdy) begin
            if (q.size() == 0) chk("soak.underflow", 32'(q.size()), 32'h1);
            else begin
               e = q.pop_front();
               chk("soak.data", 32'(o_data), 32'(e[7:0]));
               chk("soak.last", 32'(o_last), 32'(e[8]));
            end
         end
         acc = i_vld && o_rdy;
         if (acc) begin
            words++;
            for (int k = 0; k <= int'(i_nbeats); k++)
               q.push_back({k == int'(i_nbeats), i_data[k*8 +: 8]});
         end
         prev_vld = o_vld;
         prev_xfer = o_vld && i_rdy;
         tick;
         cycles++;
      end
      i_vld = 1'b0;
      chk("soak.timeout", 32'(cycles < 60000), 32'h1);
      chk("soak.words", 32'(words), 32'd4000);
      chk("soak.leftover", 32'(q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
